// File: rtl/seqdet_pkg.sv
// Shared types and width helpers for the seqdet scheduler slice.
package seqdet_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int             PLEN_D = 4;
  localparam logic [3:0]     PAT_D  = 4'b1011;

  // Index width for n items (at least one bit).
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // Width of a bit position 0..n-1 inside an n-bit word.
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seqdet_if.sv
// Request/response bundle between the stream producers and seqdet_sched.
// rsp_first exists only when SEQDET_FIRST_POS_EN is defined.
interface seqdet_if #(
  parameter int NCH  = 4,
  parameter int WLEN = 8
);
  logic [NCH-1:0]                        req;
  logic [NCH-1:0][WLEN-1:0]              req_data;
  logic [NCH-1:0]                        gnt;
  logic                                  busy;
  logic                                  rsp_valid;
  logic                                  rsp_ready;
  logic [seqdet_pkg::id_w(NCH)-1:0]      rsp_id;
  logic                                  rsp_hit;
  logic [seqdet_pkg::cnt_w(WLEN)-1:0]    rsp_count;
`ifdef SEQDET_FIRST_POS_EN
  logic [seqdet_pkg::pos_w(WLEN)-1:0]    rsp_first;
`endif

  modport master (
    output req, req_data, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, rsp_hit, rsp_count
`ifdef SEQDET_FIRST_POS_EN
    , input rsp_first
`endif
  );

  modport slave (
    input  req, req_data, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, rsp_hit, rsp_count
`ifdef SEQDET_FIRST_POS_EN
    , output rsp_first
`endif
  );
endinterface

// File: rtl/seqdet_core.sv
// Serial overlapping pattern detector: history shift register, count of
// valid history bits, and a combinational compare against the current bit.
// Assumes PLEN >= 2.
module seqdet_core import seqdet_pkg::*; #(
  parameter int              PLEN = PLEN_D,
  parameter logic [PLEN-1:0] PAT  = PAT_D
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sbit,
  output logic hit
);
  localparam int VW = cnt_w(PLEN - 1);

  logic [PLEN-2:0] hist;
  logic [VW-1:0]   vcnt;
  logic [PLEN-1:0] win;

  assign win = {hist, sbit};
  // A hit needs PLEN-1 real history bits, so cleared history never matches.
  assign hit = (vcnt == VW'(PLEN - 1)) && (win == PAT);

  // History and valid count; cleared at the start of every job.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      hist <= '0;
      vcnt <= '0;
    end else if (en) begin
      hist <= win[PLEN-2:0];
      if (vcnt != VW'(PLEN - 1)) vcnt <= vcnt + 1'b1;
    end
  end
endmodule

// File: rtl/seqdet_sched.sv
// Round-robin scheduler sharing one seqdet_core between NCH requesters.
// Optional SEQDET_FIRST_POS_EN adds rsp_first (position of the first hit).
module seqdet_sched import seqdet_pkg::*; #(
  parameter int              NCH  = 4,
  parameter int              WLEN = 8,
  parameter int              PLEN = PLEN_D,
  parameter logic [PLEN-1:0] PAT  = PAT_D
) (
  input  logic     clk,
  input  logic     rst,
  seqdet_if.slave  sif
);
  localparam int IW = id_w(NCH);
  localparam int CW = cnt_w(WLEN);
  localparam int PW = pos_w(WLEN);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, win, id_q;
  logic            any_req, start, core_hit;
  logic [NCH-1:0]  gnt;
  logic [WLEN-1:0] word;
  logic [PW-1:0]   kcnt;
  logic [CW-1:0]   count;

  // Pick the first requester at or after rr_ptr; scanning high-to-low
  // offsets lets the lowest offset win without an early exit.
  always_comb begin
    int j;
    j       = 0;
    any_req = 1'b0;
    win     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % NCH;
      if (sif.req[j]) begin
        any_req = 1'b1;
        win     = IW'(j);
      end
    end
  end

  assign start = (state == IDLE) && any_req;

  // Next state and grant pulse; grant is suppressed while reset is held.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      IDLE:  if (any_req) begin
               if (rst) gnt[win] = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: if (kcnt == PW'(WLEN - 1)) state_nxt = DONE;
      DONE:  if (sif.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Job capture, MSB-first shifting and hit counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
      word   <= '0;
      kcnt   <= '0;
      count  <= '0;
      id_q   <= '0;
    end else if (start) begin
      word   <= sif.req_data[win];
      kcnt   <= '0;
      count  <= '0;
      id_q   <= win;
      rr_ptr <= (win == IW'(NCH - 1)) ? '0 : win + 1'b1;
    end else if (state == SHIFT) begin
      word <= word << 1;
      kcnt <= kcnt + 1'b1;
      if (core_hit && count != CW'(WLEN)) count <= count + 1'b1;
    end
  end

  seqdet_core #(.PLEN(PLEN), .PAT(PAT)) u_core (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (state == SHIFT),
    .sbit (word[WLEN-1]),
    .hit  (core_hit)
  );

`ifdef SEQDET_FIRST_POS_EN
  logic [PW-1:0] first_q;

  // Bit position of the first hit in the current job.
  always_ff @(posedge clk) begin
    if (!rst || start)                                 first_q <= '0;
    else if (state == SHIFT && core_hit && count == '0) first_q <= kcnt;
  end

  assign sif.rsp_first = first_q;
`endif

  assign sif.gnt       = gnt;
  assign sif.busy      = (state != IDLE);
  assign sif.rsp_valid = (state == DONE);
  assign sif.rsp_id    = id_q;
  assign sif.rsp_count = count;
  assign sif.rsp_hit   = |count;
endmodule
